dircc_state_writeback: RTL and testbench
========================================

DIRCC_STATE_WRITEBACK -- requirements
Module: dircc_state_writeback

Interface
REQ-001 Parameter MEM_ADDRESS_WIDTH, default 32, SHALL set the width of the input address and of avm_address.
REQ-002 Parameter FIFO_DEPTH, default 4, power of two >= 2, SHALL set the number of buffered writeback entries.
REQ-003 Parameter BASE_ADDRESS, default 0, SHALL set the byte base of the device state region.
REQ-004 clk  in  1  clock; all logic on its rising edge.
REQ-005 reset_n  in  1  reset, asynchronous, active-low.
REQ-006 address  in  MEM_ADDRESS_WIDTH  device index of the state being written back.
REQ-007 write_state  in  device_state_t  new device state from the compute handler.
REQ-008 write_state_valid  in  1  single-cycle strobe qualifying address and write_state.
REQ-009 ready  out  1  high when a new entry can be accepted this cycle.
REQ-010 avm_address  out  MEM_ADDRESS_WIDTH  Avalon-MM byte address.
REQ-011 avm_write  out  1  Avalon-MM write request.
REQ-012 avm_writedata  out  $bits(device_state_t)  Avalon-MM write data.
REQ-013 avm_waitrequest  in  1  Avalon-MM slave stall.
REQ-014 overflow  out  1  sticky flag: a strobe arrived while ready was low.
REQ-015 idle  out  1  high when the FIFO is empty and avm_write is low.

Function
REQ-016 ready SHALL be combinationally high iff the FIFO holds fewer than FIFO_DEPTH entries.
REQ-017 Push: write_state_valid && ready in cycle N SHALL enqueue {address, write_state}; the entry is visible on Avalon no earlier than cycle N+1.
REQ-018 write_state_valid && !ready SHALL drop the request and set overflow, even if a pop occurs in the same cycle.
REQ-019 avm_address SHALL equal (BASE_ADDRESS + address * STATE_BYTES) mod 2^MEM_ADDRESS_WIDTH, where STATE_BYTES = ceil($bits(device_state_t)/8).
REQ-020 FSM states: IDLE (avm_write=0), ISSUE (avm_write=1, head entry presented).
REQ-021 IDLE -> ISSUE on the cycle after the FIFO becomes non-empty.
REQ-022 ISSUE: avm_address/avm_writedata/avm_write SHALL stay stable while avm_waitrequest=1.
REQ-023 ISSUE: avm_write && !avm_waitrequest SHALL pop the head; stay in ISSUE with the next entry if one remains, else -> IDLE.
REQ-024 Simultaneous push and pop SHALL leave the count unchanged; the order of Avalon writes SHALL equal the order of acceptance.
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH; a full/empty ambiguity SHALL NOT occur (count kept in log2(FIFO_DEPTH)+1 bits).

Reset
REQ-026 reset_n low SHALL asynchronously force avm_write=0, avm_address=0, avm_writedata=0, overflow=0, FIFO empty, FSM=IDLE, ready=1, idle=1.
REQ-027 Reset during ISSUE SHALL discard the in-flight and all buffered entries; no write is replayed after reset.

Configuration
REQ-028 With DIRCC_WRITEBACK_COALESCE_EN defined, a push whose address equals the tail entry's address, with the tail not being the head (count >= 2), SHALL overwrite that entry's data without a new entry, and SHALL be accepted even when full.
REQ-029 Without DIRCC_WRITEBACK_COALESCE_EN, every accepted push SHALL create a new entry.

Structure
REQ-030 The typedef writeback_entry_t (packed struct {address, state}) SHALL live in dircc_types_pkg; device_state_t SHALL come from dircc_application_pkg.
REQ-031 Storage SHALL be a sub-module dircc_writeback_fifo (parameterised depth/entry type, push/pop/count); the FSM and address arithmetic SHALL stay in dircc_state_writeback.

Verification
REQ-032 Single push addr=3, state=0xA5, waitrequest=0 -> avm_write high exactly 1 cycle, avm_address = 3*STATE_BYTES, writedata=0xA5, then idle=1.
REQ-033 5 back-to-back pushes, FIFO_DEPTH=4, waitrequest=1 -> 4 accepted, ready=0 on the 5th, overflow=1; after waitrequest drops, 4 writes are issued in order.
REQ-034 waitrequest held high for 7 cycles mid-ISSUE -> address/data/write unchanged for all 7 cycles; pop on the 8th.
REQ-035 Push on the same cycle as a pop when count=4 -> push dropped, overflow=1, count=3.
REQ-036 reset_n pulsed low while avm_write=1 with 3 entries queued -> avm_write=0 immediately, no writes after release, idle=1.
REQ-037 With the macro defined: pushes addr 1, 2, 2 (data 0x10, 0x20, 0x30) under stall -> exactly two writes: addr 1/0x10, addr 2/0x30.

Source files
------------

// File: rtl/dircc_application_pkg.sv
// Application-defined device state carried through the writeback path.
package dircc_application_pkg;

   typedef logic [19:0] device_state_t;

endpackage

// File: rtl/dircc_types_pkg.sv
// Shared writeback types: queued entry layout, FSM encoding and byte-address helper.
package dircc_types_pkg;
   import dircc_application_pkg::*;

   // Entries carry a 64-bit index so one entry type serves every MEM_ADDRESS_WIDTH up to 64.
   localparam int ENTRY_ADDRESS_WIDTH = 64;
   localparam int STATE_BITS          = $bits(device_state_t);
   localparam int STATE_BYTES         = (STATE_BITS + 7) / 8;

   typedef struct packed {
      logic [ENTRY_ADDRESS_WIDTH-1:0] address;
      device_state_t                  state;
   } writeback_entry_t;

   typedef enum logic {
      WB_IDLE  = 1'b0,
      WB_ISSUE = 1'b1
   } writeback_fsm_t;

   function automatic logic [63:0] state_byte_address(input logic [63:0] base,
                                                      input logic [63:0] index);
      return base + index * 64'(STATE_BYTES);
   endfunction

endpackage

// File: rtl/dircc_writeback_fifo.sv
// Circular buffer of writeback entries with push, pop, tail overwrite and occupancy count.
module dircc_writeback_fifo
   import dircc_types_pkg::*;
#(
   parameter int  DEPTH   = 4,
   parameter type entry_t = writeback_entry_t
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic                             push,
   input  entry_t                           push_entry,
   input  logic                             pop,
   input  logic                             overwrite,
   input  entry_t                           overwrite_entry,
   output entry_t                           head,
   output logic [ENTRY_ADDRESS_WIDTH-1:0]   tail_address,
   output logic [$clog2(DEPTH):0]           count
);

   localparam int PTR_W = $clog2(DEPTH);

   entry_t           mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] tail_ptr;

   // Power-of-two depth lets the pointers wrap naturally; count removes full/empty ambiguity.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (!push && pop) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push)           mem[wr_ptr]   <= push_entry;
      else if (overwrite) mem[tail_ptr] <= overwrite_entry;
   end

   assign tail_ptr     = wr_ptr - 1'b1;
   assign head         = mem[rd_ptr];
   assign tail_address = mem[tail_ptr].address;

endmodule

// File: rtl/dircc_state_writeback.sv
// Buffers device-state writebacks and issues them as Avalon-MM writes in acceptance order.
// Optional DIRCC_WRITEBACK_COALESCE_EN merges a push into a matching non-head tail entry.
module dircc_state_writeback
   import dircc_application_pkg::*;
   import dircc_types_pkg::*;
#(
   parameter int          MEM_ADDRESS_WIDTH = 32,
   parameter int          FIFO_DEPTH        = 4,
   parameter logic [63:0] BASE_ADDRESS      = 64'd0
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [MEM_ADDRESS_WIDTH-1:0] address,
   input  device_state_t                write_state,
   input  logic                         write_state_valid,
   output logic                         ready,
   output logic [MEM_ADDRESS_WIDTH-1:0] avm_address,
   output logic                         avm_write,
   output logic [STATE_BITS-1:0]        avm_writedata,
   input  logic                         avm_waitrequest,
   output logic                         overflow,
   output logic                         idle
);

`ifdef DIRCC_WRITEBACK_COALESCE_EN
   localparam bit COALESCE_EN = 1'b1;
`else
   localparam bit COALESCE_EN = 1'b0;
`endif

   localparam int COUNT_W = $clog2(FIFO_DEPTH) + 1;

   writeback_fsm_t                 state;
   writeback_fsm_t                 state_next;
   writeback_entry_t               head;
   writeback_entry_t               new_entry;
   logic [ENTRY_ADDRESS_WIDTH-1:0] tail_address;
   logic [COUNT_W-1:0]             count;
   logic                           push;
   logic                           pop;
   logic                           coalesce_hit;

   assign new_entry = '{address: ENTRY_ADDRESS_WIDTH'(address), state: write_state};
   assign ready     = count < COUNT_W'(FIFO_DEPTH);

   // Merging requires count >= 2 so the head being presented on Avalon never changes under it.
   assign coalesce_hit = COALESCE_EN && write_state_valid && (count >= COUNT_W'(2)) &&
                         (tail_address == new_entry.address);
   assign push = write_state_valid && ready && !coalesce_hit;
   assign pop  = avm_write && !avm_waitrequest;

   dircc_writeback_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .entry_t (writeback_entry_t)
   ) u_fifo (
      .clk             (clk),
      .reset_n         (reset_n),
      .push            (push),
      .push_entry      (new_entry),
      .pop             (pop),
      .overwrite       (coalesce_hit),
      .overwrite_entry (new_entry),
      .head            (head),
      .tail_address    (tail_address),
      .count           (count)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= WB_IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (state == WB_IDLE) begin
         if (count != '0) state_next = WB_ISSUE;
      end else begin
         if (pop && (count == COUNT_W'(1)) && !push) state_next = WB_IDLE;
      end
   end

   // Outputs are zero outside ISSUE, so reset clears the bus without resetting the storage.
   always_comb begin
      avm_write     = 1'b0;
      avm_address   = '0;
      avm_writedata = '0;
      if (state == WB_ISSUE) begin
         avm_write     = 1'b1;
         avm_address   = MEM_ADDRESS_WIDTH'(state_byte_address(BASE_ADDRESS, head.address));
         avm_writedata = head.state;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                                             overflow <= 1'b0;
      else if (write_state_valid && !ready && !coalesce_hit)    overflow <= 1'b1;
   end

   assign idle = (count == '0) && !avm_write;

endmodule

// File: tb/tb_dircc_state_writeback.sv
// Randomized self-checking bench for dircc_state_writeback against a queue-based model.
module tb_dircc_state_writeback;
   import dircc_application_pkg::*;

   localparam int AW    = 32;
   localparam int DEPTH = 4;
   localparam int DW    = $bits(device_state_t);
   localparam int SB    = (DW + 7) / 8;
`ifdef DIRCC_WRITEBACK_COALESCE_EN
   localparam bit COALESCE = 1'b1;
`else
   localparam bit COALESCE = 1'b0;
`endif

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   logic                clk;
   logic                reset_n;
   logic [AW-1:0]       address;
   device_state_t       write_state;
   logic                write_state_valid;
   logic                ready;
   logic [AW-1:0]       avm_address;
   logic                avm_write;
   logic [DW-1:0]       avm_writedata;
   logic                avm_waitrequest;
   logic                overflow;
   logic                idle;

   int total;
   int bad;

   wr_t mdl_q[$];   // model FIFO contents: raw device index + state
   wr_t exp_q[$];   // expected Avalon writes (byte address)
   wr_t obs_q[$];   // observed Avalon writes
   bit  mdl_overflow;
   int  mdl_created;

   dircc_state_writeback #(
      .MEM_ADDRESS_WIDTH (AW),
      .FIFO_DEPTH        (DEPTH),
      .BASE_ADDRESS      (64'd0)
   ) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .address           (address),
      .write_state       (write_state),
      .write_state_valid (write_state_valid),
      .ready             (ready),
      .avm_address       (avm_address),
      .avm_write         (avm_write),
      .avm_writedata     (avm_writedata),
      .avm_waitrequest   (avm_waitrequest),
      .overflow          (overflow),
      .idle              (idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [AW-1:0] byte_addr(input logic [AW-1:0] idx);
      return AW'(64'(idx) * 64'(SB));
   endfunction

   // Reference model, evaluated mid-cycle when all inputs and outputs are settled.
   always @(negedge clk) begin
      if (reset_n) begin
         bit  popped;
         bit  hit;
         wr_t e;
         popped = avm_write && !avm_waitrequest;
         if (popped) begin
            e.addr = avm_address;
            e.data = avm_writedata;
            obs_q.push_back(e);
         end
         hit = 1'b0;
         if (write_state_valid) begin
            if (COALESCE && mdl_q.size() >= 2 && mdl_q[mdl_q.size()-1].addr == address) hit = 1'b1;
            if (hit) mdl_q[mdl_q.size()-1].data = write_state;
            else if (mdl_q.size() < DEPTH) begin
               e.addr = address;
               e.data = write_state;
               mdl_q.push_back(e);
               mdl_created++;
            end else mdl_overflow = 1'b1;
         end
         if (popped) begin
            if (mdl_q.size() > 0) begin
               e = mdl_q.pop_front();
               e.addr = byte_addr(e.addr);
            end else begin
               e.addr = '1;
               e.data = '1;
            end
            exp_q.push_back(e);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_model();
      mdl_q.delete();
      exp_q.delete();
      obs_q.delete();
      mdl_overflow = 1'b0;
      mdl_created  = 0;
   endtask

   task automatic apply_reset();
      write_state_valid = 1'b0;
      avm_waitrequest   = 1'b0;
      address           = '0;
      write_state       = '0;
      #1 reset_n = 1'b0;
      clear_model();
      repeat (2) @(posedge clk);
      #2 reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      write_state_valid = 1'b0;
      avm_waitrequest = 1'b0;
      address = '0;
      write_state = '0;
      clear_model();
      repeat (2) @(posedge clk);
      #2;
      total++; if (avm_write !== 1'b0) begin bad++; $display("FAIL reset_avm_write got=%0b want=0", avm_write); end
      total++; if (avm_address !== '0) begin bad++; $display("FAIL reset_avm_address got=%0h want=0", avm_address); end
      total++; if (avm_writedata !== '0) begin bad++; $display("FAIL reset_avm_writedata got=%0h want=0", avm_writedata); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%0b want=0", overflow); end
      total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b want=1", ready); end
      total++; if (idle !== 1'b1) begin bad++; $display("FAIL reset_idle got=%0b want=1", idle); end
      reset_n = 1'b1;
      tick();
      #2;
      total++; if (ready !== 1'b1 || idle !== 1'b1 || avm_write !== 1'b0) begin
         bad++; $display("FAIL post_reset got=ready%0b/idle%0b/write%0b want=1/1/0", ready, idle, avm_write);
      end
   endtask

   task automatic test_single();
      int            hi;
      logic [AW-1:0] a_seen;
      logic [DW-1:0] d_seen;
      apply_reset();
      hi = 0; a_seen = '0; d_seen = '0;
      address = 3; write_state = 'hA5; write_state_valid = 1'b1;
      tick();
      write_state_valid = 1'b0;
      for (int c = 0; c < 12; c++) begin
         #2;
         if (avm_write === 1'b1) begin
            if (hi == 0) begin a_seen = avm_address; d_seen = avm_writedata; end
            hi++;
         end
         tick();
      end
      #2;
      total++; if (hi != 1) begin bad++; $display("FAIL single_write_cycles got=%0d want=1", hi); end
      total++; if (a_seen !== AW'(3 * SB)) begin bad++; $display("FAIL single_address got=%0h want=%0h", a_seen, 3 * SB); end
      total++; if (d_seen !== DW'('hA5)) begin bad++; $display("FAIL single_data got=%0h want=a5", d_seen); end
      total++; if (idle !== 1'b1) begin bad++; $display("FAIL single_idle got=%0b want=1", idle); end
   endtask

   task automatic test_overflow();
      wr_t pushed[5];
      apply_reset();
      avm_waitrequest = 1'b1;
      for (int i = 0; i < 5; i++) begin
         address = $urandom;
         write_state = DW'($urandom);
         write_state_valid = 1'b1;
         pushed[i].addr = address;
         pushed[i].data = write_state;
         #2;
         total++; if (ready !== (i < DEPTH)) begin bad++; $display("FAIL ovf_ready_%0d got=%0b want=%0b", i, ready, i < DEPTH); end
         tick();
      end
      write_state_valid = 1'b0;
      #2;
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0b want=1", overflow); end
      tick();
      avm_waitrequest = 1'b0;
      repeat (20) tick();
      #2;
      total++; if (idle !== 1'b1) begin bad++; $display("FAIL ovf_drain_idle got=%0b want=1", idle); end
      total++; if (obs_q.size() != DEPTH) begin bad++; $display("FAIL ovf_write_count got=%0d want=%0d", obs_q.size(), DEPTH); end
      for (int i = 0; i < DEPTH && i < obs_q.size(); i++) begin
         total++;
         if (obs_q[i].addr !== byte_addr(pushed[i].addr) || obs_q[i].data !== pushed[i].data) begin
            bad++; $display("FAIL ovf_order_%0d got=%0h/%0h want=%0h/%0h", i, obs_q[i].addr, obs_q[i].data,
                            byte_addr(pushed[i].addr), pushed[i].data);
         end
      end
   endtask

   task automatic test_stall();
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      int            w;
      apply_reset();
      avm_waitrequest = 1'b1;
      a = $urandom;
      d = DW'($urandom);
      address = a; write_state = d; write_state_valid = 1'b1;
      tick();
      write_state_valid = 1'b0;
      #2;
      w = 0;
      while (avm_write !== 1'b1 && w < 10) begin tick(); #2; w++; end
      total++; if (avm_write !== 1'b1) begin bad++; $display("FAIL stall_issue_timeout got=%0b want=1", avm_write); end
      for (int k = 1; k <= 7; k++) begin
         if (k > 1) begin tick(); #2; end
         total++;
         if (avm_write !== 1'b1 || avm_address !== byte_addr(a) || avm_writedata !== d) begin
            bad++; $display("FAIL stall_hold_%0d got=%0b/%0h/%0h want=1/%0h/%0h", k, avm_write, avm_address,
                            avm_writedata, byte_addr(a), d);
         end
      end
      total++; if (obs_q.size() != 0) begin bad++; $display("FAIL stall_early_pop got=%0d want=0", obs_q.size()); end
      tick();
      avm_waitrequest = 1'b0;
      #2;
      total++; if (avm_write !== 1'b1 || avm_address !== byte_addr(a)) begin
         bad++; $display("FAIL stall_cycle8 got=%0b/%0h want=1/%0h", avm_write, avm_address, byte_addr(a));
      end
      tick();
      #2;
      total++; if (avm_write !== 1'b0 || obs_q.size() != 1) begin
         bad++; $display("FAIL stall_pop got=%0b/%0d want=0/1", avm_write, obs_q.size());
      end
   endtask

   task automatic test_full_pop();
      wr_t pushed[4];
      int  w;
      apply_reset();
      avm_waitrequest = 1'b1;
      for (int i = 0; i < 4; i++) begin
         address = $urandom;
         write_state = DW'($urandom);
         write_state_valid = 1'b1;
         pushed[i].addr = address;
         pushed[i].data = write_state;
         tick();
      end
      write_state_valid = 1'b0;
      #2;
      w = 0;
      while (avm_write !== 1'b1 && w < 10) begin tick(); #2; w++; end
      total++; if (avm_write !== 1'b1) begin bad++; $display("FAIL fullpop_issue_timeout got=%0b want=1", avm_write); end
      tick();
      avm_waitrequest = 1'b0;
      address = $urandom;
      write_state = DW'($urandom);
      write_state_valid = 1'b1;
      #2;
      total++; if (ready !== 1'b0) begin bad++; $display("FAIL fullpop_ready got=%0b want=0", ready); end
      tick();
      write_state_valid = 1'b0;
      avm_waitrequest = 1'b1;
      #2;
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL fullpop_overflow got=%0b want=1", overflow); end
      total++; if (ready !== 1'b1) begin bad++; $display("FAIL fullpop_count3_ready got=%0b want=1", ready); end
      tick();
      avm_waitrequest = 1'b0;
      repeat (20) tick();
      #2;
      total++; if (obs_q.size() != 4) begin bad++; $display("FAIL fullpop_write_count got=%0d want=4", obs_q.size()); end
      for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
         total++;
         if (obs_q[i].addr !== byte_addr(pushed[i].addr) || obs_q[i].data !== pushed[i].data) begin
            bad++; $display("FAIL fullpop_order_%0d got=%0h/%0h want=%0h/%0h", i, obs_q[i].addr, obs_q[i].data,
                            byte_addr(pushed[i].addr), pushed[i].data);
         end
      end
   endtask

   task automatic test_reset_inflight();
      int w;
      apply_reset();
      avm_waitrequest = 1'b1;
      for (int i = 0; i < 3; i++) begin
         address = $urandom;
         write_state = DW'($urandom);
         write_state_valid = 1'b1;
         tick();
      end
      write_state_valid = 1'b0;
      #2;
      w = 0;
      while (avm_write !== 1'b1 && w < 10) begin tick(); #2; w++; end
      total++; if (avm_write !== 1'b1) begin bad++; $display("FAIL rstfl_issue_timeout got=%0b want=1", avm_write); end
      tick();
      #1 reset_n = 1'b0;
      clear_model();
      #1;
      total++; if (avm_write !== 1'b0 || avm_address !== '0 || avm_writedata !== '0) begin
         bad++; $display("FAIL rstfl_async got=%0b/%0h/%0h want=0/0/0", avm_write, avm_address, avm_writedata);
      end
      total++; if (idle !== 1'b1 || ready !== 1'b1) begin
         bad++; $display("FAIL rstfl_flags got=idle%0b/ready%0b want=1/1", idle, ready);
      end
      tick();
      reset_n = 1'b1;
      avm_waitrequest = 1'b0;
      repeat (10) tick();
      #2;
      total++; if (obs_q.size() != 0 || avm_write !== 1'b0 || idle !== 1'b1) begin
         bad++; $display("FAIL rstfl_replay got=%0d/%0b/%0b want=0/0/1", obs_q.size(), avm_write, idle);
      end
   endtask

   task automatic test_random();
      apply_reset();
      for (int c = 0; c < 400; c++) begin
         write_state_valid = ($urandom_range(0, 99) < 60);
         address = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 3);
         write_state = DW'($urandom);
         avm_waitrequest = ($urandom_range(0, 99) < 40);
         #2;
         total++; if (ready !== (mdl_q.size() < DEPTH)) begin
            bad++; $display("FAIL rand_ready_c%0d got=%0b want=%0b", c, ready, mdl_q.size() < DEPTH);
         end
         total++; if (overflow !== mdl_overflow) begin
            bad++; $display("FAIL rand_overflow_c%0d got=%0b want=%0b", c, overflow, mdl_overflow);
         end
         tick();
      end
      write_state_valid = 1'b0;
      avm_waitrequest = 1'b0;
      repeat (2 * DEPTH + 4) tick();
      #2;
      total++; if (idle !== 1'b1) begin bad++; $display("FAIL rand_drain_idle got=%0b want=1", idle); end
      total++; if (obs_q.size() != mdl_created) begin
         bad++; $display("FAIL rand_write_count got=%0d want=%0d", obs_q.size(), mdl_created);
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         total++;
         if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data) begin
            bad++; $display("FAIL rand_write_%0d got=%0h/%0h want=%0h/%0h", i, obs_q[i].addr, obs_q[i].data,
                            exp_q[i].addr, exp_q[i].data);
         end
      end
   endtask

`ifdef DIRCC_WRITEBACK_COALESCE_EN
   task automatic test_coalesce();
      logic [AW-1:0] a_list [3];
      logic [DW-1:0] d_list [3];
      a_list[0] = 1; a_list[1] = 2; a_list[2] = 2;
      d_list[0] = 'h10; d_list[1] = 'h20; d_list[2] = 'h30;
      apply_reset();
      avm_waitrequest = 1'b1;
      for (int i = 0; i < 3; i++) begin
         address = a_list[i];
         write_state = d_list[i];
         write_state_valid = 1'b1;
         tick();
      end
      write_state_valid = 1'b0;
      repeat (2) tick();
      avm_waitrequest = 1'b0;
      repeat (10) tick();
      #2;
      total++; if (obs_q.size() != 2) begin bad++; $display("FAIL coal_write_count got=%0d want=2", obs_q.size()); end
      if (obs_q.size() >= 2) begin
         total++; if (obs_q[0].addr !== byte_addr(1) || obs_q[0].data !== DW'('h10)) begin
            bad++; $display("FAIL coal_first got=%0h/%0h want=%0h/10", obs_q[0].addr, obs_q[0].data, byte_addr(1));
         end
         total++; if (obs_q[1].addr !== byte_addr(2) || obs_q[1].data !== DW'('h30)) begin
            bad++; $display("FAIL coal_second got=%0h/%0h want=%0h/30", obs_q[1].addr, obs_q[1].data, byte_addr(2));
         end
      end
   endtask
`endif

   initial begin
      total = 0;
      bad = 0;
      test_reset();
      test_single();
      test_overflow();
      test_stall();
      test_full_pop();
      test_reset_inflight();
      test_random();
`ifdef DIRCC_WRITEBACK_COALESCE_EN
      test_coalesce();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog_timeout got=running want=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
